// File: rtl/midi_note_parser.sv
// MIDI byte-stream parser: tracks running status for one channel and turns
// note-on/note-off messages into a held note, scaled velocity and trigger pulse.
module midi_note_parser #(
  parameter logic [3:0] CHANNEL = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic [7:0] midi_data,
  output logic       midi_valid,
  output logic [7:0] amplitude,
  output logic       note_trig
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_NOTE = 2'd1,
    WAIT_VEL  = 2'd2,
    SKIP      = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    RS_NONE     = 2'd0,
    RS_NOTE_OFF = 2'd1,
    RS_NOTE_ON  = 2'd2,
    RS_OTHER    = 2'd3
  } run_stat_t;

  state_t      state, state_n;
  run_stat_t   run_stat, run_stat_n;
  logic [6:0]  note, note_n;
  logic        skip_two, skip_two_n;
  logic        skip_cnt, skip_cnt_n;
  logic [7:0]  data_n, amp_n;
  logic        valid_n, trig_n;

  logic [3:0]  hi_nib, lo_nib;
  assign hi_nib = byte_in[7:4];
  assign lo_nib = byte_in[3:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      run_stat   <= RS_NONE;
      note       <= '0;
      skip_two   <= 1'b0;
      skip_cnt   <= 1'b0;
      midi_data  <= '0;
      amplitude  <= '0;
      midi_valid <= 1'b0;
      note_trig  <= 1'b0;
    end else begin
      state      <= state_n;
      run_stat   <= run_stat_n;
      note       <= note_n;
      skip_two   <= skip_two_n;
      skip_cnt   <= skip_cnt_n;
      midi_data  <= data_n;
      amplitude  <= amp_n;
      midi_valid <= valid_n;
      note_trig  <= trig_n;
    end
  end

  always_comb begin
    state_n    = state;
    run_stat_n = run_stat;
    note_n     = note;
    skip_two_n = skip_two;
    skip_cnt_n = skip_cnt;
    data_n     = midi_data;
    amp_n      = amplitude;
    valid_n    = midi_valid;
    trig_n     = 1'b0;

    if (byte_valid) begin
      if (byte_in[7]) begin
        // Real-time bytes (F8-FF) fall through untouched so they can interleave mid-message.
        if (byte_in[7:3] == 5'b11111) begin
          state_n = state;
        end else if (hi_nib == 4'hF) begin
          run_stat_n = RS_NONE;
          state_n    = IDLE;
        end else if ((hi_nib == 4'h8 || hi_nib == 4'h9) && lo_nib == CHANNEL) begin
          run_stat_n = (hi_nib == 4'h9) ? RS_NOTE_ON : RS_NOTE_OFF;
          state_n    = WAIT_NOTE;
        end else begin
          run_stat_n = RS_OTHER;
          state_n    = SKIP;
          skip_two_n = !(hi_nib == 4'hC || hi_nib == 4'hD);
          skip_cnt_n = 1'b0;
        end
      end else begin
        case (state)
          WAIT_NOTE: begin
            note_n  = byte_in[6:0];
            state_n = WAIT_VEL;
          end
          WAIT_VEL: begin
            state_n = WAIT_NOTE;
            if (run_stat == RS_NOTE_ON && byte_in[6:0] != 7'd0) begin
              data_n  = {1'b0, note};
              amp_n   = {byte_in[6:0], byte_in[6]};
              valid_n = 1'b1;
              trig_n  = 1'b1;
            end else if (midi_valid && note == midi_data[6:0]) begin
              valid_n = 1'b0;
            end
          end
          SKIP: begin
            // Counts data bytes of the foreign message; SKIP persists under running status.
            skip_cnt_n = skip_two && !skip_cnt;
          end
          default: begin
            state_n = state;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_midi_note_parser.sv
// Scoreboard bench for midi_note_parser: each driven byte queues the expected
// registered outputs, which a monitor compares one edge later.
module tb_midi_note_parser;

  logic       clk;
  logic       rst;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic [7:0] midi_data;
  logic       midi_valid;
  logic [7:0] amplitude;
  logic       note_trig;

  typedef struct {
    logic [7:0] b;
    logic [7:0] data;
    logic [7:0] amp;
    logic       valid;
    logic       trig;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_vec;
  int   n_err;

  midi_note_parser #(.CHANNEL(4'd0)) dut (
    .clk        (clk),
    .rst        (rst),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .midi_data  (midi_data),
    .midi_valid (midi_valid),
    .amplitude  (amplitude),
    .note_trig  (note_trig)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic [7:0] d, input logic [7:0] a,
                      input logic v, input logic t);
    exp_t x;
    @(negedge clk);
    x.b = b; x.data = d; x.amp = a; x.valid = v; x.trig = t;
    sb.push_back(x);
    byte_in    = b;
    byte_valid = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      if (byte_valid) begin
        #1;
        if (sb.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check($sformatf("midi_data@%02h", e.b),  {24'd0, midi_data}, {24'd0, e.data});
          check($sformatf("amplitude@%02h", e.b),  {24'd0, amplitude}, {24'd0, e.amp});
          check($sformatf("midi_valid@%02h", e.b), {31'd0, midi_valid}, {31'd0, e.valid});
          check($sformatf("note_trig@%02h", e.b),  {31'd0, note_trig}, {31'd0, e.trig});
        end
      end else begin
        #1;
        check("note_trig_idle", {31'd0, note_trig}, 32'd0);
      end
    end
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    byte_in = '0;
    byte_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_midi_data",  {24'd0, midi_data}, 32'd0);
    check("rst_amplitude",  {24'd0, amplitude}, 32'd0);
    check("rst_midi_valid", {31'd0, midi_valid}, 32'd0);
    check("rst_note_trig",  {31'd0, note_trig}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Data bytes right after reset are ignored
    send(8'h3C, 8'h00, 8'h00, 1'b0, 1'b0);
    send(8'h64, 8'h00, 8'h00, 1'b0, 1'b0);
    // Basic note-on
    send(8'h90, 8'h00, 8'h00, 1'b0, 1'b0);
    send(8'h3C, 8'h00, 8'h00, 1'b0, 1'b0);
    send(8'h64, 8'h3C, 8'hC9, 1'b1, 1'b1);
    // Running status, last-note priority
    send(8'h40, 8'h3C, 8'hC9, 1'b1, 1'b0);
    send(8'h7F, 8'h40, 8'hFF, 1'b1, 1'b1);
    // Note-off for a non-held note, then for the held one
    send(8'h80, 8'h40, 8'hFF, 1'b1, 1'b0);
    send(8'h3C, 8'h40, 8'hFF, 1'b1, 1'b0);
    send(8'h00, 8'h40, 8'hFF, 1'b1, 1'b0);
    send(8'h40, 8'h40, 8'hFF, 1'b1, 1'b0);
    send(8'h00, 8'h40, 8'hFF, 1'b0, 1'b0);
    // Real-time byte mid-message, then note-on v=0 release
    send(8'h90, 8'h40, 8'hFF, 1'b0, 1'b0);
    send(8'h3C, 8'h40, 8'hFF, 1'b0, 1'b0);
    send(8'hF8, 8'h40, 8'hFF, 1'b0, 1'b0);
    send(8'h01, 8'h3C, 8'h02, 1'b1, 1'b1);
    send(8'h3C, 8'h3C, 8'h02, 1'b1, 1'b0);
    send(8'h00, 8'h3C, 8'h02, 1'b0, 1'b0);
    // Foreign channel and 1-byte program change are skipped
    send(8'h91, 8'h3C, 8'h02, 1'b0, 1'b0);
    send(8'h3C, 8'h3C, 8'h02, 1'b0, 1'b0);
    send(8'h64, 8'h3C, 8'h02, 1'b0, 1'b0);
    send(8'hC0, 8'h3C, 8'h02, 1'b0, 1'b0);
    send(8'h05, 8'h3C, 8'h02, 1'b0, 1'b0);
    send(8'h90, 8'h3C, 8'h02, 1'b0, 1'b0);
    send(8'h30, 8'h3C, 8'h02, 1'b0, 1'b0);
    send(8'h10, 8'h30, 8'h20, 1'b1, 1'b1);
    // System common clears running status: following data is discarded
    send(8'hF0, 8'h30, 8'h20, 1'b1, 1'b0);
    send(8'h30, 8'h30, 8'h20, 1'b1, 1'b0);
    send(8'h00, 8'h30, 8'h20, 1'b1, 1'b0);
    // Control change skipped under running status
    send(8'hB0, 8'h30, 8'h20, 1'b1, 1'b0);
    send(8'h30, 8'h30, 8'h20, 1'b1, 1'b0);
    send(8'h00, 8'h30, 8'h20, 1'b1, 1'b0);
    send(8'h30, 8'h30, 8'h20, 1'b1, 1'b0);
    send(8'h00, 8'h30, 8'h20, 1'b1, 1'b0);
    // New status mid-message replaces partial note-on
    send(8'h90, 8'h30, 8'h20, 1'b1, 1'b0);
    send(8'h30, 8'h30, 8'h20, 1'b1, 1'b0);
    send(8'h80, 8'h30, 8'h20, 1'b1, 1'b0);
    send(8'h30, 8'h30, 8'h20, 1'b1, 1'b0);
    send(8'h00, 8'h30, 8'h20, 1'b0, 1'b0);
    // Velocity 0x40 scaling
    send(8'h90, 8'h30, 8'h20, 1'b0, 1'b0);
    send(8'h22, 8'h30, 8'h20, 1'b0, 1'b0);
    send(8'h40, 8'h22, 8'h81, 1'b1, 1'b1);
    // Async reset mid-message
    send(8'h90, 8'h22, 8'h81, 1'b1, 1'b0);
    send(8'h3C, 8'h22, 8'h81, 1'b1, 1'b0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("async_rst_midi_data",  {24'd0, midi_data}, 32'd0);
    check("async_rst_amplitude",  {24'd0, amplitude}, 32'd0);
    check("async_rst_midi_valid", {31'd0, midi_valid}, 32'd0);
    #1 rst = 1'b0;
    send(8'h64, 8'h00, 8'h00, 1'b0, 1'b0);
    send(8'h3C, 8'h00, 8'h00, 1'b0, 1'b0);
    send(8'h64, 8'h00, 8'h00, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #2;
    check("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
